// File: rtl/codec_config.sv
// codec_config: drives a fixed codec register init table over a simple
// request/done handshake to an external I2C master, then services
// headphone-volume rewrites (R2/R3) on request.
// Optional build macro CODEC_CFG_RETRY_EN: a NACKed write is re-issued after
// the inter-write gap, up to 3 times per entry, before the block gives up.
module codec_config #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int          WAIT_CYCLES = 16
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  vol_left,
  input  logic [6:0]  vol_right,
  input  logic        vol_update,
  output logic        i2c_req,
  output logic [6:0]  i2c_dev,
  output logic [15:0] i2c_word,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        ready,
  output logic        error
);

  // Gap counter counts WAIT_CYCLES-1 down to 0; keep at least one bit.
  localparam int GW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  // Table positions of the two volume registers and of the last init entry.
  localparam logic [3:0] IDX_VOL_L = 4'd4;
  localparam logic [3:0] IDX_VOL_R = 4'd5;
  localparam logic [3:0] IDX_LAST  = 4'd9;

  typedef enum logic [2:0] {
    IDLE, LOAD, REQ, WAIT_ACK, GAP, READY, ERR
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    idx, idx_nx;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic          pend, pend_nx;     // volume rewrite requested while busy
  logic          rw, rw_nx;         // current sequence is a volume rewrite
  logic          req_nx;
  logic [15:0]   word_nx;
  logic          ready_nx, error_nx;
  logic          adv;               // current entry finished (gap elapsed)
  logic          again;             // re-issue the same entry instead of advancing
  logic          last;
`ifdef CODEC_CFG_RETRY_EN
  logic [1:0]    retry_cnt, retry_nx;
  logic          redo, redo_nx;
`endif

  // Register word for a table index: {reg_addr[6:0], reg_data[8:0]}.
  function automatic logic [15:0] tbl_word(input logic [3:0] i,
                                           input logic [6:0] vl,
                                           input logic [6:0] vr);
    logic [6:0] ra;
    logic [8:0] rd;
    ra = 7'd0;
    rd = 9'h000;
    case (i)
      4'd0: begin ra = 7'd15; rd = 9'h000;         end  // reset
      4'd1: begin ra = 7'd6;  rd = 9'h000;         end  // power up
      4'd2: begin ra = 7'd0;  rd = 9'h017;         end  // left line in
      4'd3: begin ra = 7'd1;  rd = 9'h017;         end  // right line in
      4'd4: begin ra = 7'd2;  rd = {2'b01, vl};    end  // left headphone
      4'd5: begin ra = 7'd3;  rd = {2'b01, vr};    end  // right headphone
      4'd6: begin ra = 7'd4;  rd = 9'h012;         end  // analog path
      4'd7: begin ra = 7'd5;  rd = 9'h000;         end  // digital path
      4'd8: begin ra = 7'd7;  rd = 9'h00A;         end  // interface format
      4'd9: begin ra = 7'd9;  rd = 9'h001;         end  // activate
      default: begin ra = 7'd0; rd = 9'h000;       end
    endcase
    return {ra, rd};
  endfunction

  assign i2c_dev = DEV_ADDR;
  assign busy    = state inside {LOAD, REQ, WAIT_ACK, GAP};
  assign last    = rw ? (idx == IDX_VOL_R) : (idx == IDX_LAST);

  // Next-state and next-register values; every target defaults to hold.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    gap_nx   = gap_cnt;
    pend_nx  = pend;
    rw_nx    = rw;
    req_nx   = i2c_req;
    word_nx  = i2c_word;
    ready_nx = ready;
    error_nx = error;
    adv      = 1'b0;
    again    = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
    retry_nx = retry_cnt;
    redo_nx  = redo;
`endif

    case (state)
      IDLE, ERR: begin
        // Rewrites make no sense before a good init; drop any request.
        pend_nx = 1'b0;
        if (start) begin
          state_nx = LOAD;
          idx_nx   = 4'd0;
          rw_nx    = 1'b0;
          ready_nx = 1'b0;
          error_nx = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
          retry_nx = 2'd0;
          redo_nx  = 1'b0;
`endif
        end
      end
      READY: begin
        // start outranks a same-cycle (or pending) volume rewrite.
        if (start) begin
          state_nx = LOAD;
          idx_nx   = 4'd0;
          rw_nx    = 1'b0;
          pend_nx  = 1'b0;
          ready_nx = 1'b0;
          error_nx = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
          retry_nx = 2'd0;
          redo_nx  = 1'b0;
`endif
        end else if (vol_update || pend) begin
          state_nx = LOAD;
          idx_nx   = IDX_VOL_L;
          rw_nx    = 1'b1;
          pend_nx  = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
          retry_nx = 2'd0;
          redo_nx  = 1'b0;
`endif
        end
      end
      LOAD: begin
        // Volume codes are taken here so late changes are honoured.
        word_nx  = tbl_word(idx, vol_left, vol_right);
        req_nx   = 1'b1;
        state_nx = REQ;
      end
      REQ: begin
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (i2c_done) begin
          req_nx = 1'b0;
          if (i2c_nack) begin
`ifdef CODEC_CFG_RETRY_EN
            if (retry_cnt == 2'd3) begin
              state_nx = ERR;
              error_nx = 1'b1;
            end else begin
              retry_nx = retry_cnt + 2'd1;
              redo_nx  = 1'b1;
              if (WAIT_CYCLES == 0) adv = 1'b1;
              else begin
                state_nx = GAP;
                gap_nx   = GAP_LAST;
              end
            end
`else
            state_nx = ERR;
            error_nx = 1'b1;
`endif
          end else begin
`ifdef CODEC_CFG_RETRY_EN
            redo_nx = 1'b0;
`endif
            if (WAIT_CYCLES == 0) adv = 1'b1;
            else begin
              state_nx = GAP;
              gap_nx   = GAP_LAST;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) adv = 1'b1;
        else               gap_nx = gap_cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase

`ifdef CODEC_CFG_RETRY_EN
    again = redo_nx;
`endif

    // Entry complete: repeat it, move on, or finish the sequence.
    if (adv) begin
      if (again) begin
        state_nx = LOAD;
      end else if (last) begin
        state_nx = READY;
        ready_nx = 1'b1;
      end else begin
        state_nx = LOAD;
        idx_nx   = idx + 4'd1;
`ifdef CODEC_CFG_RETRY_EN
        retry_nx = 2'd0;
`endif
      end
    end

    // Rewrite requests during a sequence collapse into one pending flag.
    if (busy && vol_update) pend_nx = 1'b1;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= 4'd0;
      gap_cnt  <= '0;
      pend     <= 1'b0;
      rw       <= 1'b0;
      i2c_req  <= 1'b0;
      i2c_word <= 16'h0000;
      ready    <= 1'b0;
      error    <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
      retry_cnt <= 2'd0;
      redo      <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      gap_cnt  <= gap_nx;
      pend     <= pend_nx;
      rw       <= rw_nx;
      i2c_req  <= req_nx;
      i2c_word <= word_nx;
      ready    <= ready_nx;
      error    <= error_nx;
`ifdef CODEC_CFG_RETRY_EN
      retry_cnt <= retry_nx;
      redo      <= redo_nx;
`endif
    end
  end

endmodule

// File: tb/tb_codec_config.sv
// tb_codec_config: randomized bench for codec_config with an I2C master
// model, a request monitor and a table-driven reference of expected words.
module tb_codec_config;
  localparam int W = 16;

  typedef logic [15:0] wq_t[$];

  logic        sys_clk = 1'b0;
  logic        reset, start, vol_update, i2c_done, i2c_nack;
  logic [6:0]  vol_left, vol_right, i2c_dev;
  logic        i2c_req, busy, ready, error;
  logic [15:0] i2c_word;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  logic [15:0] got_q[$];
  int          rise_cyc[$];
  int          done_cyc[$];
  bit          nack_plan[$];
  int          ack_dly = 5;
  int          hold_at = -1;
  bit          force_done = 1'b0;
  int          stab_viol = 0;
  bit          watch_ready = 1'b0;
  int          ready_drop = 0;

  codec_config #(.DEV_ADDR(7'h1A), .WAIT_CYCLES(W)) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start),
    .vol_left(vol_left), .vol_right(vol_right), .vol_update(vol_update),
    .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_word(i2c_word),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .busy(busy), .ready(ready), .error(error)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: codec register table as plain address/data arrays.
  function automatic logic [15:0] ref_word(int idx, logic [6:0] vl, logic [6:0] vr);
    int ra[10] = '{15, 6, 0, 1, 2, 3, 4, 5, 7, 9};
    int rd[10] = '{'h000, 'h000, 'h017, 'h017, 0, 0, 'h012, 'h000, 'h00A, 'h001};
    int d;
    d = rd[idx];
    if (idx == 4) d = 'h80 + int'(vl);
    if (idx == 5) d = 'h80 + int'(vr);
    return 16'(ra[idx] * 512 + d);
  endfunction

  function automatic wq_t init_words(logic [6:0] vl, logic [6:0] vr);
    wq_t q;
    for (int i = 0; i < 10; i++) q.push_back(ref_word(i, vl, vr));
    return q;
  endfunction

  // Monitor + I2C master model, one process so ordering is deterministic.
  initial begin : bus
    logic        prev_req;
    logic [15:0] prev_word;
    int          cnt;
    prev_req = 1'b0; prev_word = 16'h0; cnt = 0;
    i2c_done = 1'b0; i2c_nack = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (i2c_req && !prev_req) begin
        got_q.push_back(i2c_word);
        rise_cyc.push_back(cyc);
      end
      if (i2c_req && prev_req && i2c_word !== prev_word) stab_viol++;
      if (watch_ready && !ready) ready_drop++;
      prev_req  = i2c_req;
      prev_word = i2c_word;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (force_done) begin
        i2c_done = 1'b1;
        force_done = 1'b0;
        cnt = 0;
      end else if (i2c_req && got_q.size() != hold_at) begin
        cnt++;
        if (cnt == ack_dly) begin
          i2c_done = 1'b1;
          i2c_nack = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
          done_cyc.push_back(cyc);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clear_log();
    got_q.delete(); rise_cyc.delete(); done_cyc.delete(); nack_plan.delete();
  endtask

  // Wait until the block has been idle (busy=0) for 4 cycles, bounded.
  task automatic wait_quiet(input string tag, input int max_cyc);
    int q;
    q = 0;
    for (int i = 0; i < max_cyc && q < 4; i++) begin
      @(negedge sys_clk);
      if (!busy) q++; else q = 0;
    end
    if (q < 4) chk({tag, " timeout"}, 32'd1, 32'd0);
  endtask

  task automatic cmp_seq(input string tag, input wq_t exp);
    chk({tag, " count"}, got_q.size(), exp.size());
    foreach (exp[i])
      if (i < got_q.size()) chk($sformatf("%s word%0d", tag, i), got_q[i], exp[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic pulse_vol();
    vol_update = 1'b1;
    @(negedge sys_clk);
    vol_update = 1'b0;
  endtask

  initial begin : main
    int s;
    logic [6:0] vl, vr;
    wq_t exp;
    bit hit;

    reset = 1'b0; start = 1'b0; vol_update = 1'b0; vol_left = 7'h0; vol_right = 7'h0;
    tick(3);
    chk("rst req", i2c_req, 0);
    chk("rst word", i2c_word, 0);
    chk("rst busy", busy, 0);
    chk("rst ready", ready, 0);
    chk("rst error", error, 0);
    chk("dev addr", i2c_dev, 7'h1A);

    // Idle after release; a stray done must not wake the block.
    reset = 1'b1;
    force_done = 1'b1;
    tick(8);
    chk("idle no req", got_q.size(), 0);
    chk("idle busy", busy, 0);

    // Full init; vol_left changes after start and must be picked up in LOAD.
    clear_log();
    ack_dly = 5;
    vol_left = 7'h05; vol_right = 7'($urandom);
    start = 1'b1; s = cyc;
    chk("busy at start", busy, 0);
    @(negedge sys_clk);
    start = 1'b0; vol_left = 7'h79;
    chk("busy after start", busy, 1);
    wait_quiet("init", 1500);
    cmp_seq("init", init_words(7'h79, vol_right));
    chk("init word4", (got_q.size() > 4) ? got_q[4] : 16'h0, 16'h04F9);
    chk("init ready", ready, 1);
    chk("init busy", busy, 0);
    chk("init error", error, 0);
    if (rise_cyc.size() > 0) chk("req latency", rise_cyc[0] - s, 2);
    if (rise_cyc.size() > 1 && done_cyc.size() > 0)
      chk("gap len", rise_cyc[1] - done_cyc[0], W + 2);

    // Volume rewrites from READY.
    for (int k = 0; k < 3; k++) begin
      clear_log();
      vl = (k == 0) ? 7'h30 : 7'($urandom);
      vr = (k == 0) ? 7'h40 : 7'($urandom);
      ack_dly = (k == 0) ? 5 : int'($urandom_range(2, 8));
      vol_left = vl; vol_right = vr;
      ready_drop = 0; watch_ready = 1'b1;
      pulse_vol();
      chk($sformatf("rw%0d busy", k), busy, 1);
      wait_quiet("rewrite", 400);
      watch_ready = 1'b0;
      exp.delete();
      exp.push_back(ref_word(4, vl, vr));
      exp.push_back(ref_word(5, vl, vr));
      cmp_seq($sformatf("rw%0d", k), exp);
      chk($sformatf("rw%0d ready held", k), ready_drop, 0);
      chk($sformatf("rw%0d ready", k), ready, 1);
    end

    // start and vol_update together in READY: init only.
    clear_log();
    ack_dly = int'($urandom_range(2, 8));
    vl = 7'($urandom); vr = 7'($urandom);
    vol_left = vl; vol_right = vr;
    start = 1'b1; vol_update = 1'b1;
    @(negedge sys_clk);
    start = 1'b0; vol_update = 1'b0;
    wait_quiet("start+vol", 1500);
    cmp_seq("start+vol", init_words(vl, vr));
    chk("start+vol ready", ready, 1);

    // Three vol_update pulses during init collapse into one rewrite.
    clear_log();
    ack_dly = int'($urandom_range(2, 8));
    vl = 7'($urandom); vr = 7'($urandom);
    vol_left = vl; vol_right = vr;
    pulse_start();
    repeat (3) begin
      tick(int'($urandom_range(10, 50)));
      pulse_vol();
    end
    wait_quiet("pend", 2000);
    exp = init_words(vl, vr);
    exp.push_back(ref_word(4, vl, vr));
    exp.push_back(ref_word(5, vl, vr));
    cmp_seq("pend", exp);
    chk("pend ready", ready, 1);

    // NACK on entry 4.
`ifdef CODEC_CFG_RETRY_EN
    clear_log();
    ack_dly = 5;
    nack_plan = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    pulse_start();
    wait_quiet("retry ok", 2500);
    exp.delete();
    for (int i = 0; i < 4; i++) exp.push_back(ref_word(i, vl, vr));
    repeat (4) exp.push_back(ref_word(4, vl, vr));
    for (int i = 5; i < 10; i++) exp.push_back(ref_word(i, vl, vr));
    cmp_seq("retry ok", exp);
    chk("retry ok ready", ready, 1);
    chk("retry ok error", error, 0);

    clear_log();
    nack_plan = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    pulse_start();
    tick(10);
    pulse_vol();
    wait_quiet("retry fail", 2500);
    exp.delete();
    for (int i = 0; i < 4; i++) exp.push_back(ref_word(i, vl, vr));
    repeat (4) exp.push_back(ref_word(4, vl, vr));
`else
    clear_log();
    ack_dly = 5;
    nack_plan = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pulse_start();
    tick(10);
    pulse_vol();
    wait_quiet("nack", 1500);
    exp.delete();
    for (int i = 0; i < 5; i++) exp.push_back(ref_word(i, vl, vr));
`endif
    cmp_seq("nack", exp);
    chk("nack error", error, 1);
    chk("nack busy", busy, 0);
    chk("nack ready", ready, 0);
    tick(40);
    chk("nack no more req", got_q.size(), exp.size());
    pulse_vol();
    tick(40);
    chk("err vol ignored", got_q.size(), exp.size());
    chk("err busy", busy, 0);

    // Restart from ERR: full init, no leftover rewrite.
    clear_log();
    pulse_start();
    wait_quiet("restart", 1500);
    cmp_seq("restart", init_words(vl, vr));
    chk("restart error", error, 0);
    chk("restart ready", ready, 1);

    // Reset while the 7th request (entry 6) is outstanding.
    clear_log();
    hold_at = 7;
    vl = 7'($urandom); vr = 7'($urandom);
    vol_left = vl; vol_right = vr;
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 1500 && !hit; i++) begin
      @(negedge sys_clk);
      if (got_q.size() == 7 && i2c_req) hit = 1'b1;
    end
    if (!hit) chk("hold timeout", 32'd1, 32'd0);
    tick(3);
    reset = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("mid rst req", i2c_req, 0);
    chk("mid rst word", i2c_word, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst ready", ready, 0);
    chk("mid rst error", error, 0);
    @(negedge sys_clk);
    reset = 1'b1;
    hold_at = -1;
    force_done = 1'b1;
    tick(20);
    chk("late done ignored", got_q.size(), 7);
    chk("late done busy", busy, 0);
    chk("late done req", i2c_req, 0);

    clear_log();
    pulse_start();
    wait_quiet("rerun", 1500);
    cmp_seq("rerun", init_words(vl, vr));
    chk("rerun ready", ready, 1);

    chk("word stable", stab_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
